tmeasure_collector: RTL and testbench
=====================================

# tmeasure_collector

Downstream control-and-reduction stage for the multi-phase period-measurement array. It issues one start pulse to the array and waits for the array's busy flag to rise and then fall. It then reads the ten per-phase counter values one per cycle and produces their sum, minimum and maximum for the frequency-computation stage. A watchdog aborts the measurement if the array never completes.

## Interface
Parameters:
- N_PHASES, 10, number of per-phase counter values consumed
- VAL_W, 32, width of each counter value
- SUM_W, 36, width of sum; must be ≥ VAL_W + ceil(log2(N_PHASES))
- TIMEOUT, 2**24, max cycles spent waiting on the array before abort

Ports:
- clk  in  1  single clock; the same clock as phase 0 of the array
- rst_n  in  1  reset; asynchronous, active-low
- req  in  1  measurement request, level-sampled
- busy  out  1  high while a measurement is in progress
- meas_start  out  1  start pulse to the array
- meas_busy  in  1  array busy flag
- val  in  N_PHASES×VAL_W  per-phase counter values, unsigned
- result_sum  out  SUM_W  sum of all val entries
- result_min  out  VAL_W  smallest val entry
- result_max  out  VAL_W  largest val entry
- result_valid  out  1  results are valid; a level, not a pulse
- timeout  out  1  last measurement aborted by the watchdog

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, ACCUM, DONE.
- IDLE or DONE with req=1 → LAUNCH. On this transition:
  - clear result_valid and timeout;
  - clear the watchdog counter.
- LAUNCH: meas_start=1 for exactly this one cycle → WAIT_ACK.
- WAIT_ACK: meas_busy=1 → WAIT_DONE.
- WAIT_DONE: meas_busy=0 → ACCUM. On this transition:
  - index=0, sum=0, min=all-ones, max=0.
- ACCUM: on each cycle, for val[index]:
  - add it to sum;
  - update min and max with it;
  - increment index.
  - After index N_PHASES-1 is processed → DONE.
- Result registers load from the working registers on entry to DONE.
- DONE:
  - result_valid=1;
  - results are held until the next accepted req.
- Watchdog:
  - the counter increments on every cycle spent in WAIT_ACK or WAIT_DONE;
  - when it reaches TIMEOUT-1 → DONE with timeout=1, result_sum=0, result_min=0, result_max=0, result_valid=1.
- busy=1 in LAUNCH, WAIT_ACK, WAIT_DONE and ACCUM; busy=0 in IDLE and DONE.
- Arithmetic:
  - val is zero-extended to SUM_W before addition, so no overflow is possible within the width rule;
  - min and max use unsigned comparisons.
- While busy=1, req is ignored; it is not queued.
- Illegal state encoding → IDLE, with meas_start=0.

## Timing
- Reset values: busy=0, meas_start=0, result_sum=0, result_min=0, result_max=0, result_valid=0, timeout=0; state=IDLE.
- meas_start, busy and result_valid are registered outputs.
- Pulse timing: req high at edge t in IDLE → meas_start=1 and busy=1 during cycle t+1 only; meas_start=0 from t+2.
- Latency from completion: first edge d at which meas_busy=0 is sampled in WAIT_DONE → ACCUM covers d+1 … d+N_PHASES → result_valid=1 and busy=0 from edge d+N_PHASES+1.
- val is sampled only in ACCUM; it must be stable from edge d through d+N_PHASES.
- meas_busy already 0 at the cycle after LAUNCH: stay in WAIT_ACK. A completion is only recognised after a seen rise of meas_busy.
- Watchdog expiring in the same cycle meas_busy changes: the timeout wins.
- req held high continuously: a new measurement starts the cycle after entry to DONE, so result_valid is high for exactly one cycle.
- rst_n asserted mid-operation:
  - all outputs return to reset values immediately (asynchronously);
  - meas_start drops even during LAUNCH.

## Test plan
- Basic measurement:
  - stimulus: reset; req=1 for one cycle; array model raises meas_busy 1 cycle after meas_start and drops it 50 cycles later; val = 100,101,…,109.
  - required: single-cycle meas_start; result_sum=1045, result_min=100, result_max=109, result_valid=1 at d+11, timeout=0.
- Extremes:
  - stimulus: all val = 0xFFFFFFFF.
  - required: result_sum = 0x9_FFFF_FFF6; min = max = 0xFFFFFFFF.
- Watchdog:
  - stimulus: TIMEOUT=64; meas_busy stuck high.
  - required: timeout=1, result_valid=1 and all results 0 after 64 wait cycles; busy=0.
- Back-to-back requests:
  - stimulus: req held high across two measurements.
  - required: second meas_start one cycle after first DONE; result_valid high for exactly one cycle between runs.
  - stimulus: req pulsed while busy=1.
  - required: no extra measurement.
- Reset mid-run:
  - stimulus: rst_n asserted during ACCUM at index 5, then released; then a fresh req.
  - required: all outputs 0 immediately; the fresh req yields correct results with no residue from the aborted run.
- Late acknowledge:
  - stimulus: meas_busy rises 3 cycles after meas_start.
  - required: wait in WAIT_ACK, then complete normally with correct sum.

Source files
------------

// File: rtl/tmeasure_collector_if.sv
// Request, array-control and result bundle of the period-measurement collector.
// master: requester plus array side; slave: the collector itself.
interface tmeasure_collector_if #(
  parameter int N_PHASES = 10,
  parameter int VAL_W    = 32,
  parameter int SUM_W    = 36
);
  logic                           req;
  logic                           busy;
  logic                           meas_start;
  logic                           meas_busy;
  logic [N_PHASES-1:0][VAL_W-1:0] val;
  logic [SUM_W-1:0]               result_sum;
  logic [VAL_W-1:0]               result_min;
  logic [VAL_W-1:0]               result_max;
  logic                           result_valid;
  logic                           timeout;

  modport master (
    output req, meas_busy, val,
    input  busy, meas_start, result_sum,
    input  result_min, result_max,
    input  result_valid, timeout
  );

  modport slave (
    input  req, meas_busy, val,
    output busy, meas_start, result_sum,
    output result_min, result_max,
    output result_valid, timeout
  );
endinterface

// File: rtl/tmeasure_collector.sv
// Launches one array measurement, waits for completion, then reduces the
// per-phase counts to sum/min/max. A watchdog aborts a stuck array.
module tmeasure_collector #(
  parameter int N_PHASES = 10,
  parameter int VAL_W    = 32,
  parameter int SUM_W    = 36,
  parameter int TIMEOUT  = 2**24
) (
  input logic clk,
  input logic rst_n,
  tmeasure_collector_if.slave bus
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IX_W = $clog2(N_PHASES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [IX_W-1:0] IX_END = IX_W'(N_PHASES);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, ACCUM, DONE
  } state_t;

  state_t state, state_nxt;

  logic [WD_W-1:0]  wd, wd_nxt;
  logic [IX_W-1:0]  idx, idx_nxt;
  logic [SUM_W-1:0] acc_sum, acc_sum_nxt;
  logic [VAL_W-1:0] acc_min, acc_min_nxt;
  logic [VAL_W-1:0] acc_max, acc_max_nxt;
  logic [SUM_W-1:0] r_sum, r_sum_nxt;
  logic [VAL_W-1:0] r_min, r_min_nxt;
  logic [VAL_W-1:0] r_max, r_max_nxt;
  logic             r_to, r_to_nxt;
  logic             r_busy, r_start, r_valid;
  logic             busy_nxt;
  logic [VAL_W-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd;
    idx_nxt     = idx;
    acc_sum_nxt = acc_sum;
    acc_min_nxt = acc_min;
    acc_max_nxt = acc_max;
    r_sum_nxt   = r_sum;
    r_min_nxt   = r_min;
    r_max_nxt   = r_max;
    r_to_nxt    = r_to;
    v           = '0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.req) begin
          state_nxt = LAUNCH;
          r_to_nxt  = 1'b0;
          wd_nxt    = '0;
        end
      end
      LAUNCH: state_nxt = WAIT_ACK;
      WAIT_ACK, WAIT_DONE: begin
        // watchdog expiry takes priority over any meas_busy edge
        if (wd == WD_MAX) begin
          state_nxt = DONE;
          r_to_nxt  = 1'b1;
          r_sum_nxt = '0;
          r_min_nxt = '0;
          r_max_nxt = '0;
        end else begin
          wd_nxt = wd + WD_W'(1);
          if (state == WAIT_ACK && bus.meas_busy) begin
            state_nxt = WAIT_DONE;
          end else if (state == WAIT_DONE && !bus.meas_busy) begin
            state_nxt   = ACCUM;
            idx_nxt     = '0;
            acc_sum_nxt = '0;
            acc_min_nxt = '1;
            acc_max_nxt = '0;
          end
        end
      end
      ACCUM: begin
        if (idx == IX_END) begin
          state_nxt = DONE;
          r_sum_nxt = acc_sum;
          r_min_nxt = acc_min;
          r_max_nxt = acc_max;
        end else begin
          v           = bus.val[idx];
          acc_sum_nxt = acc_sum + SUM_W'(v);
          if (v < acc_min) acc_min_nxt = v;
          if (v > acc_max) acc_max_nxt = v;
          idx_nxt = idx + IX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == LAUNCH)   ||
                    (state_nxt == WAIT_ACK) ||
                    (state_nxt == WAIT_DONE) ||
                    (state_nxt == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      idx     <= '0;
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      wd      <= wd_nxt;
      idx     <= idx_nxt;
      acc_sum <= acc_sum_nxt;
      acc_min <= acc_min_nxt;
      acc_max <= acc_max_nxt;
      r_sum   <= r_sum_nxt;
      r_min   <= r_min_nxt;
      r_max   <= r_max_nxt;
      r_to    <= r_to_nxt;
      r_busy  <= busy_nxt;
      r_start <= (state_nxt == LAUNCH);
      r_valid <= (state_nxt == DONE);
    end
  end

  assign bus.busy         = r_busy;
  assign bus.meas_start   = r_start;
  assign bus.result_sum   = r_sum;
  assign bus.result_min   = r_min;
  assign bus.result_max   = r_max;
  assign bus.result_valid = r_valid;
  assign bus.timeout      = r_to;
endmodule

// File: tb/tb_tmeasure_collector.sv
// Directed bench for tmeasure_collector: normal runs, extremes, watchdog,
// back-to-back requests, ignored requests and reset mid-accumulation.
module tb_tmeasure_collector;
  localparam int NP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  tmeasure_collector_if #(.N_PHASES(NP), .VAL_W(32), .SUM_W(36)) bus ();

  tmeasure_collector #(
    .N_PHASES(NP), .VAL_W(32), .SUM_W(36), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_start"}, 64'(bus.meas_start), 64'd0);
    check({tag, "_sum"}, 64'(bus.result_sum), 64'd0);
    check({tag, "_min"}, 64'(bus.result_min), 64'd0);
    check({tag, "_max"}, 64'(bus.result_max), 64'd0);
    check({tag, "_valid"}, 64'(bus.result_valid), 64'd0);
    check({tag, "_to"}, 64'(bus.timeout), 64'd0);
  endtask

  // leaves caller at the negedge following edge t (LAUNCH cycle)
  task automatic start_run(input bit keep);
    bus.req = 1'b1;
    @(negedge clk);
    check("start_hi", 64'(bus.meas_start), 64'd1);
    check("start_busy", 64'(bus.busy), 64'd1);
    if (!keep) bus.req = 1'b0;
  endtask

  task automatic array_run(input int ack_dly, input int blen,
                           input bit pulse, input logic [35:0] esum,
                           input logic [31:0] emin,
                           input logic [31:0] emax);
    @(negedge clk);
    check("start_lo", 64'(bus.meas_start), 64'd0);
    for (int i = 1; i < ack_dly; i++) begin
      check("ack_wait_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    bus.meas_busy = 1'b1;
    for (int i = 0; i < blen; i++) begin
      if (pulse && i == 5) bus.req = 1'b1;
      if (pulse && i == 6) bus.req = 1'b0;
      @(negedge clk);
    end
    bus.meas_busy = 1'b0;
    repeat (NP + 1) @(negedge clk);
    check("pre_valid", 64'(bus.result_valid), 64'd0);
    check("pre_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("valid", 64'(bus.result_valid), 64'd1);
    check("done_busy", 64'(bus.busy), 64'd0);
    check("sum", 64'(bus.result_sum), 64'(esum));
    check("min", 64'(bus.result_min), 64'(emin));
    check("max", 64'(bus.result_max), 64'(emax));
    check("to", 64'(bus.timeout), 64'd0);
  endtask

  initial begin
    bus.req = 1'b0;
    bus.meas_busy = 1'b0;
    bus.val = '0;
    repeat (3) @(negedge clk);
    chk_idle_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("idle");

    // basic: 100..109
    for (int i = 0; i < NP; i++) bus.val[i] = 32'(100 + i);
    start_run(1'b0);
    array_run(1, 50, 1'b0, 36'd1045, 32'd100, 32'd109);

    // extremes
    for (int i = 0; i < NP; i++) bus.val[i] = 32'hFFFF_FFFF;
    start_run(1'b0);
    array_run(1, 8, 1'b0, 36'h9_FFFF_FFF6, 32'hFFFF_FFFF,
              32'hFFFF_FFFF);

    // late ack plus a req pulse while busy
    bus.val[0] = 32'd7;  bus.val[1] = 32'd3;
    bus.val[2] = 32'd9;  bus.val[3] = 32'd1;
    bus.val[4] = 32'd12; bus.val[5] = 32'd5;
    bus.val[6] = 32'd8;  bus.val[7] = 32'd2;
    bus.val[8] = 32'd6;  bus.val[9] = 32'd4;
    start_run(1'b0);
    array_run(3, 20, 1'b1, 36'd57, 32'd1, 32'd12);
    repeat (3) @(negedge clk);
    check("noq_start", 64'(bus.meas_start), 64'd0);
    check("noq_busy", 64'(bus.busy), 64'd0);
    check("noq_valid", 64'(bus.result_valid), 64'd1);

    // back-to-back with req held high
    for (int i = 0; i < NP; i++) bus.val[i] = 32'(i + 1);
    start_run(1'b1);
    array_run(1, 6, 1'b0, 36'd55, 32'd1, 32'd10);
    @(negedge clk);
    check("b2b_valid_1cyc", 64'(bus.result_valid), 64'd0);
    check("b2b_restart", 64'(bus.meas_start), 64'd1);
    bus.req = 1'b0;
    for (int i = 0; i < NP; i++) bus.val[i] = 32'(i);
    array_run(1, 6, 1'b0, 36'd45, 32'd0, 32'd9);

    // watchdog: meas_busy stuck high
    start_run(1'b0);
    bus.meas_busy = 1'b1;
    repeat (64) @(negedge clk);
    check("wd_pre_valid", 64'(bus.result_valid), 64'd0);
    check("wd_pre_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("wd_to", 64'(bus.timeout), 64'd1);
    check("wd_valid", 64'(bus.result_valid), 64'd1);
    check("wd_busy", 64'(bus.busy), 64'd0);
    check("wd_sum", 64'(bus.result_sum), 64'd0);
    check("wd_min", 64'(bus.result_min), 64'd0);
    check("wd_max", 64'(bus.result_max), 64'd0);
    bus.meas_busy = 1'b0;

    // reset during accumulation at index 5
    for (int i = 0; i < NP; i++) bus.val[i] = 32'(1000 + i);
    start_run(1'b0);
    array_run(1, 4, 1'b0, 36'd10045, 32'd1000, 32'd1009);
    start_run(1'b0);
    @(negedge clk);
    bus.meas_busy = 1'b1;
    repeat (10) @(negedge clk);
    bus.meas_busy = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) bus.val[i] = 32'(2 * i + 1);
    @(negedge clk);
    start_run(1'b0);
    array_run(1, 10, 1'b0, 36'd100, 32'd1, 32'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
